// File: rtl/fetch_pair_aligner_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pair_aligner_pkg
// Shared definitions for the fetch pair aligner: halfword/word types, the
// prefix byte constants recognised in front of an opcode halfword, the
// filler used in the upper half of a single-op istrWord, and the output
// classification used while forming the istrWord.
// ---------------------------------------------------------------------------
package fetch_pair_aligner_pkg;

    typedef logic [15:0] halfword_t;
    typedef logic [31:0] word_t;

    localparam logic [7:0] PFX_8E = 8'h8E;
    localparam logic [7:0] PFX_CE = 8'hCE;
    localparam logic [7:0] PFX_8A = 8'h8A;

    localparam halfword_t UV16_NOPAD = 16'h0000;

    // What the head of the halfword queue currently offers to decode.
    typedef enum logic [1:0] {
        OUT_NONE,
        OUT_SINGLE,
        OUT_PAIR
    } out_kind_e;

    // A halfword is a prefix when its upper byte is one of the prefix codes.
    function automatic logic is_prefix(input halfword_t h);
        return (h[15:8] == PFX_8E) || (h[15:8] == PFX_CE) || (h[15:8] == PFX_8A);
    endfunction

endpackage

// File: rtl/fetch_pair_aligner_if.sv
// ---------------------------------------------------------------------------
// fetch_pair_aligner_if
// Bundles the three handshakes around the aligner:
//   fetch side : ifData / ifValid / ifReady   (aligned 32-bit fetch blocks)
//   redirect   : idFlush / idFlushPc          (branch or exception restart)
//   decode side: odWord / odPc / odIsPair / odValid / odReady (istrWord)
// master : the surrounding core (I-cache path, decode stage, redirect logic)
// slave  : the aligner itself
// ---------------------------------------------------------------------------
interface fetch_pair_aligner_if;
    import fetch_pair_aligner_pkg::*;

    word_t ifData;
    logic  ifValid;
    logic  ifReady;
    logic  idFlush;
    word_t idFlushPc;
    word_t odWord;
    word_t odPc;
    logic  odIsPair;
    logic  odValid;
    logic  odReady;

    modport master (
        output ifData, ifValid, idFlush, idFlushPc, odReady,
        input  ifReady, odWord, odPc, odIsPair, odValid
    );

    modport slave (
        input  ifData, ifValid, idFlush, idFlushPc, odReady,
        output ifReady, odWord, odPc, odIsPair, odValid
    );

endinterface

// File: rtl/fetch_pair_aligner_halfword_fifo.sv
// ---------------------------------------------------------------------------
// fetch_pair_aligner_halfword_fifo
// Halfword queue kept as a shift register so that the two oldest entries are
// always at fixed positions (head0, head1) for the prefix/pair logic.
// Ports:
//   clock, reset     : core clock, synchronous active-low clear
//   flush            : synchronous clear, wins over push and pop
//   push_cnt         : 0/1/2 halfwords to append (push_lo first, then push_hi)
//   pop_cnt          : 0/1/2 halfwords removed from the head
//   head0, head1     : oldest and second-oldest entries
//   count            : current occupancy 0..DEPTH
//   count_next       : occupancy after this cycle's push/pop/flush
// The caller guarantees pop_cnt <= count and that count_next never exceeds
// DEPTH.
// ---------------------------------------------------------------------------
module fetch_pair_aligner_halfword_fifo
    import fetch_pair_aligner_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [1:0]                   push_cnt,
    input  halfword_t                    push_lo,
    input  halfword_t                    push_hi,
    input  logic [1:0]                   pop_cnt,
    output halfword_t                    head0,
    output halfword_t                    head1,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [$clog2(DEPTH+1)-1:0]   count_next
);

    localparam int CW = $clog2(DEPTH + 1);

    halfword_t [DEPTH-1:0] mem_q;
    halfword_t [DEPTH-1:0] mem_d;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;

    // Popped entries are shifted out of the bottom first; the survivors then
    // occupy slots 0..base-1 and new halfwords land at base and base+1.
    always_comb begin
        halfword_t [DEPTH-1:0] shifted;
        logic [CW-1:0]         base;
        mem_d   = mem_q;
        shifted = mem_q >> {pop_cnt, 4'b0000};
        base    = count_q - CW'(pop_cnt);
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = shifted[i];
            if ((push_cnt != 2'd0) && (CW'(i) == base)) begin
                mem_d[i] = push_lo;
            end
            if ((push_cnt == 2'd2) && (CW'(i) == base + CW'(1))) begin
                mem_d[i] = push_hi;
            end
        end
        count_d = base + CW'(push_cnt);
        if (flush) begin
            count_d = '0;
        end
    end

    // Storage and occupancy registers; contents are zeroed on reset so the
    // head (and therefore odWord) reads as zero straight out of reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_q   <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

    assign head0      = mem_q[0];
    assign head1      = mem_q[1];
    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/fetch_pair_aligner.sv
// ---------------------------------------------------------------------------
// fetch_pair_aligner
// Turns aligned 32-bit fetch blocks into one istrWord per decode handshake:
// either a single 16-bit op ({16'h0000, op}) or a prefix+opcode pair packed
// as {opcode, prefix}. Tracks the PC of the queue head and whether the first
// halfword of the next fetch block lies before the redirect target.
// Parameters:
//   DEPTH    : halfword queue depth (4 or 6)
//   RESET_PC : PC loaded at reset
// Ports:
//   clock, reset : core clock, synchronous active-low reset
//   bus          : fetch, redirect and decode handshakes (slave modport)
// ---------------------------------------------------------------------------
module fetch_pair_aligner
    import fetch_pair_aligner_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clock,
    input  logic                 reset,
    fetch_pair_aligner_if.slave  bus
);

    localparam int CW = $clog2(DEPTH + 1);

    halfword_t     head0;
    halfword_t     head1;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    out_kind_e     out_kind;
    logic          od_valid;
    word_t         od_word;

    logic [1:0]    push_cnt;
    logic [1:0]    pop_cnt;
    halfword_t     push_lo;
    halfword_t     push_hi;

    word_t         pc_q;
    word_t         pc_d;
    logic          drop_first_q;
    logic          drop_first_d;
    logic          if_ready_q;
    logic          if_ready_d;

    fetch_pair_aligner_halfword_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (bus.idFlush),
        .push_cnt   (push_cnt),
        .push_lo    (push_lo),
        .push_hi    (push_hi),
        .pop_cnt    (pop_cnt),
        .head0      (head0),
        .head1      (head1),
        .count      (count),
        .count_next (count_next)
    );

    // Classify the queue head. A lone prefix is held back until its opcode
    // halfword arrives; two prefixes in a row still form a pair and the
    // decoder sorts out whether that is legal.
    always_comb begin
        out_kind = OUT_NONE;
        if (count >= CW'(2)) begin
            out_kind = is_prefix(head0) ? OUT_PAIR : OUT_SINGLE;
        end else if (count == CW'(1)) begin
            out_kind = is_prefix(head0) ? OUT_NONE : OUT_SINGLE;
        end
    end

    // Build the istrWord. The word is forced to zero whenever nothing is
    // offered so decode never sees stale queue contents.
    always_comb begin
        od_valid = 1'b0;
        od_word  = '0;
        case (out_kind)
            OUT_SINGLE: begin
                od_valid = 1'b1;
                od_word  = {UV16_NOPAD, head0};
            end
            OUT_PAIR: begin
                od_valid = 1'b1;
                od_word  = {head1, head0};
            end
            default: begin
                od_valid = 1'b0;
                od_word  = '0;
            end
        endcase
    end

    // Queue traffic for this cycle. When the previous redirect landed on the
    // upper halfword of a block, the lower halfword is skipped once.
    always_comb begin
        push_cnt = 2'd0;
        push_lo  = bus.ifData[15:0];
        push_hi  = bus.ifData[31:16];
        pop_cnt  = 2'd0;
        if (bus.ifValid && if_ready_q) begin
            if (drop_first_q) begin
                push_cnt = 2'd1;
                push_lo  = bus.ifData[31:16];
            end else begin
                push_cnt = 2'd2;
            end
        end
        if (od_valid && bus.odReady) begin
            pop_cnt = (out_kind == OUT_PAIR) ? 2'd2 : 2'd1;
        end
    end

    // Next PC, skip flag and fetch-ready. A redirect overrides any traffic
    // in the same cycle. Ready is computed from the next occupancy and then
    // registered, so a two-halfword push can never overflow the queue and
    // odReady has no combinational route to ifReady.
    always_comb begin
        pc_d         = pc_q + {29'd0, pop_cnt, 1'b0};
        drop_first_d = drop_first_q;
        if (push_cnt != 2'd0) begin
            drop_first_d = 1'b0;
        end
        if (bus.idFlush) begin
            pc_d         = bus.idFlushPc & 32'hFFFF_FFFE;
            drop_first_d = bus.idFlushPc[1];
        end
        if_ready_d = (count_next <= CW'(DEPTH - 2));
    end

    // Aligner state registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q         <= RESET_PC;
            drop_first_q <= RESET_PC[1];
            if_ready_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            drop_first_q <= drop_first_d;
            if_ready_q   <= if_ready_d;
        end
    end

    assign bus.ifReady  = if_ready_q;
    assign bus.odValid  = od_valid;
    assign bus.odWord   = od_word;
    assign bus.odIsPair = (out_kind == OUT_PAIR);
    assign bus.odPc     = pc_q;

endmodule

// File: tb/tb_fetch_pair_aligner.sv
// ---------------------------------------------------------------------------
// tb_fetch_pair_aligner
// Drives the aligner through the directed scenarios (singles, pairs, split
// pair, backpressure, flush, PC wrap) and then a long randomized run. A
// queue-based model of the halfword stream is compared against the DUT on
// every falling edge; accepted transfers are also logged so the directed
// scenarios can be pinned to hand-computed literals.
// ---------------------------------------------------------------------------
module tb_fetch_pair_aligner;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_1000;

    logic clock = 1'b0;
    logic reset;

    fetch_pair_aligner_if bus();

    fetch_pair_aligner #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] w;
        logic [31:0] pc;
        logic        pair;
    } xfer_t;

    xfer_t       got[$];
    logic [15:0] mq[$];
    logic [31:0] mpc;
    logic        mdrop;
    logic        mready;
    bit          modelOk = 1'b0;

    function automatic bit isPfx(input logic [15:0] h);
        return (h[15:8] == 8'h8E) || (h[15:8] == 8'hCE) || (h[15:8] == 8'h8A);
    endfunction

    function automatic logic [15:0] randHw();
        logic [15:0] h;
        h = 16'($urandom);
        case ($urandom_range(0, 9))
            0: h[15:8] = 8'h8E;
            1: h[15:8] = 8'hCE;
            2: h[15:8] = 8'h8A;
            default: ;
        endcase
        return h;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic checkGot(input string name, input int idx, input logic [31:0] w,
                            input logic [31:0] pc, input logic pair);
        if (idx < got.size()) begin
            checkOutput({name, "_word"}, got[idx].w, w);
            checkOutput({name, "_pc"}, got[idx].pc, pc);
            checkOutput({name, "_pair"}, 32'(got[idx].pair), 32'(pair));
        end else begin
            total++;
            bad++;
            $display("[TB] FAIL %s missing transfer actual_count=%0d required_index=%0d", name, got.size(), idx);
        end
    endtask

    // Compare the DUT against the halfword-stream model, log accepted
    // transfers, then advance the model with the inputs that the coming
    // rising edge will sample.
    always @(negedge clock) begin
        int          n;
        bit          ev;
        bit          ep;
        logic [31:0] ew;
        n  = mq.size();
        ev = 1'b0;
        ep = 1'b0;
        ew = '0;
        if (n >= 1) begin
            if (!isPfx(mq[0])) begin
                ev = 1'b1;
                ew = {16'h0000, mq[0]};
            end else if (n >= 2) begin
                ev = 1'b1;
                ep = 1'b1;
                ew = {mq[1], mq[0]};
            end
        end
        if (modelOk) begin
            checkOutput("odValid", 32'(bus.odValid), 32'(ev));
            checkOutput("ifReady", 32'(bus.ifReady), 32'(mready));
            checkOutput("odPc", bus.odPc, mpc);
            if (ev) begin
                checkOutput("odWord", bus.odWord, ew);
                checkOutput("odIsPair", 32'(bus.odIsPair), 32'(ep));
            end
            if (bus.odValid && bus.odReady && !bus.idFlush && reset) begin
                got.push_back('{w: bus.odWord, pc: bus.odPc, pair: bus.odIsPair});
            end
        end
        if (!reset) begin
            mq.delete();
            mpc     = RESET_PC;
            mdrop   = RESET_PC[1];
            modelOk = 1'b1;
        end else if (bus.idFlush) begin
            mq.delete();
            mpc   = {bus.idFlushPc[31:1], 1'b0};
            mdrop = bus.idFlushPc[1];
        end else begin
            if (ev && bus.odReady) begin
                void'(mq.pop_front());
                mpc = mpc + 32'd2;
                if (ep) begin
                    void'(mq.pop_front());
                    mpc = mpc + 32'd2;
                end
            end
            if (bus.ifValid && mready) begin
                if (!mdrop) begin
                    mq.push_back(bus.ifData[15:0]);
                end
                mq.push_back(bus.ifData[31:16]);
                mdrop = 1'b0;
            end
        end
        mready = reset && (mq.size() <= DEPTH - 2);
    end

    task automatic syncUp();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) syncUp();
    endtask

    // Offer one fetch block and hold it until the aligner takes it.
    task automatic applyStimulus(input logic [31:0] data);
        bit r;
        bit done;
        done        = 1'b0;
        bus.ifValid = 1'b1;
        bus.ifData  = data;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clock);
            r = bus.ifReady;
            syncUp();
            if (r) done = 1'b1;
        end
        bus.ifValid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout actual=not_accepted required=accepted data=%h", data);
        end
    endtask

    task automatic doReset();
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(1);
        got.delete();
    endtask

    initial begin
        reset         = 1'b0;
        bus.ifValid   = 1'b0;
        bus.ifData    = '0;
        bus.idFlush   = 1'b0;
        bus.idFlushPc = '0;
        bus.odReady   = 1'b1;
        idle(2);

        @(negedge clock);
        checkOutput("rst_odValid", 32'(bus.odValid), 32'd0);
        checkOutput("rst_ifReady", 32'(bus.ifReady), 32'd0);
        checkOutput("rst_odPc", bus.odPc, 32'h0000_1000);
        checkOutput("rst_odWord", bus.odWord, 32'h0000_0000);
        checkOutput("rst_odIsPair", 32'(bus.odIsPair), 32'd0);
        syncUp();
        reset = 1'b1;
        idle(1);
        got.delete();

        $display("[TB] two singles");
        applyStimulus(32'h200B_6012);
        idle(4);
        checkOutput("t1_count", got.size(), 32'd2);
        checkGot("t1_a", 0, 32'h0000_6012, 32'h0000_1000, 1'b0);
        checkGot("t1_b", 1, 32'h0000_200B, 32'h0000_1002, 1'b0);

        $display("[TB] prefix pair");
        doReset();
        applyStimulus(32'h3123_8E05);
        idle(3);
        checkOutput("t2_count", got.size(), 32'd1);
        checkGot("t2_a", 0, 32'h3123_8E05, 32'h0000_1000, 1'b1);
        @(negedge clock);
        checkOutput("t2_nextPc", bus.odPc, 32'h0000_1004);
        syncUp();

        $display("[TB] split pair");
        doReset();
        applyStimulus(32'h8E05_6012);
        idle(3);
        @(negedge clock);
        checkOutput("t3_lonePrefix", 32'(bus.odValid), 32'd0);
        syncUp();
        applyStimulus(32'hAAAA_4103);
        idle(4);
        checkOutput("t3_count", got.size(), 32'd3);
        checkGot("t3_a", 0, 32'h0000_6012, 32'h0000_1000, 1'b0);
        checkGot("t3_b", 1, 32'h4103_8E05, 32'h0000_1002, 1'b1);
        checkGot("t3_c", 2, 32'h0000_AAAA, 32'h0000_1006, 1'b0);

        $display("[TB] backpressure");
        doReset();
        bus.odReady = 1'b0;
        applyStimulus(32'h0002_0001);
        applyStimulus(32'h0004_0003);
        @(negedge clock);
        checkOutput("t4_full", 32'(bus.ifReady), 32'd0);
        syncUp();
        bus.odReady = 1'b1;
        applyStimulus(32'h0006_0005);
        idle(8);
        checkOutput("t4_count", got.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            checkGot("t4", i, 32'(i + 1), 32'h0000_1000 + 32'(2 * i), 1'b0);
        end

        $display("[TB] flush");
        doReset();
        bus.odReady = 1'b0;
        applyStimulus(32'h5555_4444);
        bus.idFlush   = 1'b1;
        bus.idFlushPc = 32'h0000_2002;
        bus.ifValid   = 1'b1;
        bus.ifData    = 32'h7777_6666;
        bus.odReady   = 1'b1;
        syncUp();
        bus.idFlush = 1'b0;
        bus.ifValid = 1'b0;
        got.delete();
        @(negedge clock);
        checkOutput("t5_afterFlush", 32'(bus.odValid), 32'd0);
        checkOutput("t5_flushPc", bus.odPc, 32'h0000_2002);
        syncUp();
        applyStimulus(32'h1111_2222);
        idle(4);
        checkOutput("t5_count", got.size(), 32'd1);
        checkGot("t5_a", 0, 32'h0000_1111, 32'h0000_2002, 1'b0);

        $display("[TB] pc wrap");
        bus.idFlush   = 1'b1;
        bus.idFlushPc = 32'hFFFF_FFFE;
        syncUp();
        bus.idFlush = 1'b0;
        got.delete();
        applyStimulus(32'h0009_1234);
        idle(3);
        checkOutput("t6_count", got.size(), 32'd1);
        checkGot("t6_a", 0, 32'h0000_0009, 32'hFFFF_FFFE, 1'b0);
        @(negedge clock);
        checkOutput("t6_wrapPc", bus.odPc, 32'h0000_0000);
        syncUp();

        $display("[TB] random traffic");
        for (int c = 0; c < 3000; c++) begin
            bus.ifValid   = ($urandom_range(0, 99) < 70);
            bus.ifData    = {randHw(), randHw()};
            bus.odReady   = ($urandom_range(0, 99) < 75);
            bus.idFlush   = ($urandom_range(0, 99) < 3);
            bus.idFlushPc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7)))
                                                        : 32'($urandom);
            reset         = !($urandom_range(0, 999) < 4);
            syncUp();
        end
        bus.ifValid = 1'b0;
        bus.idFlush = 1'b0;
        bus.odReady = 1'b1;
        reset       = 1'b1;
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
